// File: rtl/vga_pattern_timing.sv
// VGA timing generator and four-mode test-pattern source; BORDER_EN adds a white frame border.
// Latency: every output is registered one clk after the (h_cnt, v_cnt) it describes.
// Backpressure: none; free-running source, pattern select and colour latched once per frame.
module vga_pattern_timing #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             mode,
   input  logic [3*COLOR_W-1:0]   solid_rgb,
   output logic                   hsync,
   output logic                   vsync,
   output logic [COLOR_W-1:0]     VGA_R,
   output logic [COLOR_W-1:0]     VGA_G,
   output logic [COLOR_W-1:0]     VGA_B,
   output logic                   active,
   output logic [11:0]            x,
   output logic [11:0]            y,
   output logic                   frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
   localparam logic [12:0] H_ACT13  = 13'(H_ACTIVE);
   localparam logic [12:0] V_ACT13  = 13'(V_ACTIVE);
   localparam logic [12:0] HS_BEG   = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] VS_BEG   = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [12:0] H_EDGE   = 13'(H_ACTIVE - 1);
   localparam logic [12:0] V_EDGE   = 13'(V_ACTIVE - 1);

   // Reject geometries the bar comparator and 12-bit counters cannot represent
   generate
      if ((H_ACTIVE % 8) != 0 || H_TOTAL > 4096 || V_TOTAL > 4096 || CLK_DIV < 1) begin : g_param_error
         $fatal(1, "vga_pattern_timing: illegal timing parameters");
      end
   endgenerate

   logic [DIV_W-1:0]       div_cnt;
   logic [11:0]            h_cnt;
   logic [11:0]            v_cnt;
   logic [1:0]             mode_sh;
   logic [3*COLOR_W-1:0]   rgb_sh;

   logic                   pix_ce;
   logic                   wrap;
   logic [12:0]            h_ext;
   logic [12:0]            v_ext;
   logic                   act_c;
   logic                   hs_c;
   logic                   vs_c;
   logic [2:0]             bar_k;
   logic [2:0]             bar_bits;
   logic [3*COLOR_W-1:0]   pat;

   assign pix_ce = (div_cnt == DIV_LAST);
   assign wrap   = pix_ce && (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign h_ext  = {1'b0, h_cnt};
   assign v_ext  = {1'b0, v_cnt};
   assign act_c  = (h_ext < H_ACT13) && (v_ext < V_ACT13);
   assign hs_c   = (h_ext >= HS_BEG && h_ext < HS_END) ? HS_POL : ~HS_POL;
   assign vs_c   = (v_ext >= VS_BEG && v_ext < VS_END) ? VS_POL : ~VS_POL;

   // Pixel divider, raster counters and per-frame shadow of the pattern controls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
         mode_sh <= '0;
         rgb_sh  <= '0;
      end else begin
         div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
         if (pix_ce) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
               h_cnt <= h_cnt + 12'd1;
            end
         end
         if (wrap) begin
            mode_sh <= mode;
            rgb_sh  <= solid_rgb;
         end
      end
   end

   // Colour-bar index by threshold comparison so no divider is built
   always_comb begin
      bar_k = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h_ext >= 13'(i * BAR_W)) bar_k = 3'(i);
      end
      case (bar_k)
         3'd0:    bar_bits = 3'b111;   // white
         3'd1:    bar_bits = 3'b110;   // yellow
         3'd2:    bar_bits = 3'b011;   // cyan
         3'd3:    bar_bits = 3'b010;   // green
         3'd4:    bar_bits = 3'b101;   // magenta
         3'd5:    bar_bits = 3'b100;   // red
         3'd6:    bar_bits = 3'b001;   // blue
         default: bar_bits = 3'b000;   // black
      endcase
   end

   // Pattern mux, optional border override, blanking outside the visible area
   always_comb begin
      case (mode_sh)
         2'd0:    pat = rgb_sh;
         2'd1:    pat = {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}}, {COLOR_W{bar_bits[0]}}};
         2'd2:    pat = {(3*COLOR_W){h_cnt[5] ^ v_cnt[5]}};
         default: pat = {h_cnt[COLOR_W+3:4], v_cnt[COLOR_W+3:4], {COLOR_W{1'b0}}};
      endcase
`ifdef BORDER_EN
      if (h_ext == 13'd0 || h_ext == H_EDGE || v_ext == 13'd0 || v_ext == V_EDGE) begin
         pat = '1;
      end
`endif
      if (!act_c) pat = '0;
   end

   // Output registers, all sampled from the same counter state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         active      <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         hsync       <= hs_c;
         vsync       <= vs_c;
         active      <= act_c;
         x           <= h_cnt;
         y           <= v_cnt;
         frame_start <= wrap;
         VGA_R       <= pat[3*COLOR_W-1:2*COLOR_W];
         VGA_G       <= pat[2*COLOR_W-1:COLOR_W];
         VGA_B       <= pat[COLOR_W-1:0];
      end
   end

endmodule

// File: tb/tb_vga_pattern_timing.sv
// Scoreboard bench for vga_pattern_timing on a reduced 80x48 raster (64x40 visible, 2 clks/pixel).
// Stimulus pushes hand-computed timing and pixel expectations; a monitor pops them as the DUT shows them.
// Frame length is 80*48*2 = 7680 clks; hsync falls at (64+4)*2+1 = 137 clks after release.
module tb_vga_pattern_timing;

   localparam int CW = 4;
`ifdef BORDER_EN
   localparam bit BRD = 1'b1;
`else
   localparam bit BRD = 1'b0;
`endif

   localparam int K_HS_FALL = 0, K_HS_LOW = 1, K_HS_PER = 2, K_VS_FALL = 3,
                  K_VS_LOW = 4, K_FS_FIRST = 5, K_FS_XY = 6, K_FS_PER = 7;

   logic            clk;
   logic            reset;
   logic [1:0]      mode;
   logic [3*CW-1:0] solid_rgb;
   logic            hsync, vsync, active, frame_start;
   logic [CW-1:0]   vga_r, vga_g, vga_b;
   logic [11:0]     x, y;

   vga_pattern_timing #(
      .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
      .hsync(hsync), .vsync(vsync), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .active(active), .x(x), .y(y), .frame_start(frame_start)
   );

   typedef struct {
      string      name;
      int         frame;
      int         px;
      int         py;
      logic [11:0] rgb;
      logic       act;
   } pix_t;

   typedef struct {
      string name;
      int    kind;
      int    val;
   } tim_t;

   pix_t pq[$];
   tim_t tq[$];
   int   checks = 0;
   int   fails  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push_pix(input string n, input int f, input int px, input int py,
                           input logic [11:0] rgb, input logic act);
      pix_t e;
      e.name = n; e.frame = f; e.px = px; e.py = py; e.rgb = rgb; e.act = act;
      pq.push_back(e);
   endtask

   task automatic push_tim(input string n, input int kind, input int val);
      tim_t e;
      e.name = n; e.kind = kind; e.val = val;
      tq.push_back(e);
   endtask

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", n, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int   cyc, frm, last_fall, vs_fall, fs_prev;
   bit   have_fall, xy_pend;
   logic prev_hs, prev_vs;

   task automatic report(input int kind, input int val);
      if (tq.size() > 0 && tq[0].kind == kind) begin
         checks++;
         if (val != tq[0].val) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tq[0].name, val, tq[0].val);
         end
         void'(tq.pop_front());
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            cyc = 0; frm = 0; have_fall = 0; xy_pend = 0; fs_prev = -1;
            last_fall = 0; vs_fall = 0; prev_hs = 1'b1; prev_vs = 1'b1;
         end else begin
            cyc++;
            if (xy_pend) begin
               report(K_FS_XY, int'(x) * 4096 + int'(y));
               xy_pend = 0;
            end
            if (prev_hs && !hsync) begin
               if (!have_fall) report(K_HS_FALL, cyc);
               else            report(K_HS_PER, cyc - last_fall);
               last_fall = cyc;
               have_fall = 1;
            end
            if (!prev_hs && hsync) report(K_HS_LOW, cyc - last_fall);
            if (prev_vs && !vsync) begin
               report(K_VS_FALL, cyc);
               vs_fall = cyc;
            end
            if (!prev_vs && vsync) report(K_VS_LOW, cyc - vs_fall);
            if (frame_start) begin
               if (fs_prev < 0) report(K_FS_FIRST, cyc);
               else             report(K_FS_PER, cyc - fs_prev);
               fs_prev = cyc;
               frm++;
               xy_pend = 1;
            end
            prev_hs = hsync;
            prev_vs = vsync;
            if (pq.size() > 0 && pq[0].frame == frm && int'(x) == pq[0].px && int'(y) == pq[0].py) begin
               checks++;
               if ({vga_r, vga_g, vga_b} !== pq[0].rgb || active !== pq[0].act) begin
                  fails++;
                  $display("FAIL %s got rgb=%h act=%b exp rgb=%h act=%b",
                           pq[0].name, {vga_r, vga_g, vga_b}, active, pq[0].rgb, pq[0].act);
               end
               void'(pq.pop_front());
            end
         end
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_fs(input string tag);
      int n;
      n = 0;
      while (n < 20000) begin
         @(posedge clk); #1;
         if (frame_start) break;
         n++;
      end
      if (n >= 20000) begin
         checks++; fails++;
         $display("FAIL timeout_%s got=none exp=frame_start", tag);
      end
   endtask

   task automatic wait_xy(input string tag, input int wx, input int wy);
      int n;
      n = 0;
      while (n < 20000) begin
         @(posedge clk); #1;
         if ((wx < 0 || int'(x) == wx) && (wy < 0 || int'(y) == wy)) break;
         n++;
      end
      if (n >= 20000) begin
         checks++; fails++;
         $display("FAIL timeout_%s got=none exp=x%0d_y%0d", tag, wx, wy);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      mode = 2'd1;
      solid_rgb = 12'h000;
      #3;
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_active", int'(active), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);

      push_tim("hs_first_fall", K_HS_FALL, 137);
      push_tim("hs_low_width", K_HS_LOW, 16);
      push_tim("hs_period", K_HS_PER, 160);
      push_tim("vs_first_fall", K_VS_FALL, 6721);
      push_tim("vs_low_width", K_VS_LOW, 480);
      push_tim("fs_first", K_FS_FIRST, 7680);
      push_tim("fs_xy_zero", K_FS_XY, 0);
      push_tim("fs_period", K_FS_PER, 7680);

      // frame 0: shadow registers still hold mode 0 / colour 0 from reset
      push_pix("f0_x0_y5", 0, 0, 5, BRD ? 12'hFFF : 12'h000, 1'b1);
      push_pix("f0_x1_y5", 0, 1, 5, 12'h000, 1'b1);
      push_pix("f0_x8_y5", 0, 8, 5, 12'h000, 1'b1);
      push_pix("f0_x5_y39", 0, 5, 39, BRD ? 12'hFFF : 12'h000, 1'b1);
      // frame 1: colour bars, 8 pixels wide
      push_pix("bar_white", 1, 0, 5, 12'hFFF, 1'b1);
      push_pix("bar_yellow", 1, 8, 5, 12'hFF0, 1'b1);
      push_pix("bar_cyan", 1, 16, 5, 12'h0FF, 1'b1);
      push_pix("bar_red", 1, 40, 5, 12'hF00, 1'b1);
      push_pix("bar_last", 1, 63, 5, BRD ? 12'hFFF : 12'h000, 1'b1);
      push_pix("bar_blank", 1, 64, 5, 12'h000, 1'b0);
      // frame 2: solid green, mode switch to checker mid-frame must not show yet
      push_pix("solid_31_0", 2, 31, 0, BRD ? 12'hFFF : 12'h0F0, 1'b1);
      push_pix("solid_32_0", 2, 32, 0, BRD ? 12'hFFF : 12'h0F0, 1'b1);
      push_pix("solid_after_sw", 2, 5, 30, 12'h0F0, 1'b1);
      // frame 3: checker
      push_pix("chk_31_0", 3, 31, 0, BRD ? 12'hFFF : 12'h000, 1'b1);
      push_pix("chk_32_0", 3, 32, 0, 12'hFFF, 1'b1);
      push_pix("chk_5_32", 3, 5, 32, 12'hFFF, 1'b1);
      push_pix("chk_32_32", 3, 32, 32, 12'h000, 1'b1);
      // frame 4: gradient R=x[7:4], G=y[7:4]
      push_pix("grad_47_1", 4, 47, 1, 12'h200, 1'b1);
      push_pix("grad_16_33", 4, 16, 33, 12'h120, 1'b1);

      repeat (3) @(negedge clk);
      reset = 1'b0;

      wait_fs("frame1");
      wait_xy("f1_y20", -1, 20);
      mode = 2'd0;
      solid_rgb = 12'h0F0;
      wait_fs("frame2");
      wait_xy("f2_y10", -1, 10);
      mode = 2'd2;
      wait_fs("frame3");
      wait_xy("f3_y40", -1, 40);
      mode = 2'd3;
      wait_fs("frame4");
      wait_xy("f4_y40", -1, 40);

      // asynchronous reset mid-line, between clock edges
      wait_xy("mid_line", 50, -1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_hsync", int'(hsync), 1);
      chk("arst_vsync", int'(vsync), 1);
      chk("arst_x", int'(x), 0);
      chk("arst_y", int'(y), 0);
      chk("arst_active", int'(active), 0);
      chk("arst_rgb", int'({vga_r, vga_g, vga_b}), 0);
      push_tim("re_hs_first_fall", K_HS_FALL, 137);
      push_tim("re_hs_low_width", K_HS_LOW, 16);
      push_tim("re_hs_period", K_HS_PER, 160);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int n = 0; n < 2000 && tq.size() > 0; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      #2;
      while (tq.size() > 0) begin
         checks++; fails++;
         $display("FAIL %s got=missing exp=%0d", tq[0].name, tq[0].val);
         void'(tq.pop_front());
      end
      while (pq.size() > 0) begin
         checks++; fails++;
         $display("FAIL %s got=missing exp=%h", pq[0].name, pq[0].rgb);
         void'(pq.pop_front());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
